// File: rtl/imem_loader_if.sv
// imem_loader_if: loader byte stream, fetch read port and load status of the instruction memory
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [31:0]       fetch_addr;
    logic [31:0]       fetch_instr;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   load_words;

    modport master (
        output ld_valid, ld_data, ld_last, fetch_addr,
        input  ld_ready, fetch_instr, cpu_hold, load_done, load_err, load_words
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, fetch_addr,
        output ld_ready, fetch_instr, cpu_hold, load_done, load_err, load_words
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into instruction memory words, holds the CPU until loaded, serves registered fetch reads; CHECKSUM_EN adds a trailing XOR checksum byte
module imem_loader #(
    parameter int DEPTH_WORDS = 32,
    parameter int ADDR_W      = 5
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {LOAD, DONE, ERR, CHK} state_t;
    localparam state_t FIN = CHK;
    logic [7:0] csum;
`else
    typedef enum logic [1:0] {LOAD, DONE, ERR} state_t;
    localparam state_t FIN = DONE;
`endif
    state_t state, state_nx;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] instr;
    logic [23:0] shift;
    logic [1:0] byte_cnt;
    logic [ADDR_W:0] words;
    logic accept, full, load_acc;
    assign accept = bus.ld_valid & bus.ld_ready;
    // words never exceeds DEPTH_WORDS, a power of two, so the top bit marks a full memory
    assign full = words[ADDR_W];
    assign load_acc = accept & (state == LOAD) & ~full;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (accept && state == LOAD)
            state_nx = full || (bus.ld_last && byte_cnt != 2'd3) ? ERR : bus.ld_last ? FIN : LOAD;
`ifdef CHECKSUM_EN
        if (accept && state == CHK) state_nx = bus.ld_data == csum ? DONE : ERR;
`endif
    end
    always_comb begin
        bus.ld_ready  = state != DONE && state != ERR;
        bus.cpu_hold  = state != DONE;
        bus.load_done = state == DONE;
        bus.load_err  = state == ERR;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            shift    <= '0;
            words    <= '0;
            instr    <= '0;
`ifdef CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            if (load_acc) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) words <= words + 1'b1;
                else shift[8*byte_cnt +: 8] <= bus.ld_data;
`ifdef CHECKSUM_EN
                csum <= csum ^ bus.ld_data;
`endif
            end
            instr <= bus.fetch_addr[31:ADDR_W+2] == '0 ? mem[bus.fetch_addr[ADDR_W+1:2]] : '0;
        end
    end
    always_ff @(posedge clk)
        if (load_acc && byte_cnt == 2'd3) mem[words[ADDR_W-1:0]] <= {bus.ld_data, shift};
    assign bus.fetch_instr = instr;
    assign bus.load_words  = words;
endmodule
